mult_seq_kh: RTL

MULT_SEQ_KH -- requirements
Module: mult_seq_kh

---
 rtl/mult_seq_kh.sv | 105 ++++++++++
 1 files changed

// File: rtl/mult_seq_kh.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per cycle.
// Signed mode multiplies magnitudes and applies the sign once at the end.
module mult_seq_kh #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc_next;

  // The most negative operand maps to 2^(WIDTH-1), which fits as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    logic signed [WIDTH-1:0] sx;
    sx = signed'(x);
    return (sm && sx < 0) ? unsigned'(-sx) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] p, input logic n);
    logic signed [2*WIDTH-1:0] sp;
    sp = signed'(p);
    return n ? unsigned'(-sp) : p;
  endfunction

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{WIDTH{1'b0}}, mag(a, signed_mode)};
            mplier   <= mag(b, signed_mode);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Final bit folds into the result directly so DONE starts on this edge.
          if (cnt == LAST) begin
            result    <= cond_neg(acc_next, neg);
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
